// File: rtl/controlador_baterias_if.sv
// Signal bundle between the battery charge sensors / manual request and the
// dual load-switch controller. The master side drives charges and requests.
interface controlador_baterias_if;
    logic [3:0] carga_bateria1;
    logic [3:0] carga_bateria2;
    logic       forzar_cambio;
    logic       habilitar_bateria1;
    logic       habilitar_bateria2;
    logic       bateria_activa;
    logic       conmutando;
    logic       alarma_sin_carga;
    logic [7:0] num_conmutaciones;
    logic [2:0] estado_dbg;

    modport master (
        output carga_bateria1, carga_bateria2, forzar_cambio,
        input  habilitar_bateria1, habilitar_bateria2, bateria_activa,
               conmutando, alarma_sin_carga, num_conmutaciones, estado_dbg
    );

    modport slave (
        input  carga_bateria1, carga_bateria2, forzar_cambio,
        output habilitar_bateria1, habilitar_bateria2, bateria_activa,
               conmutando, alarma_sin_carga, num_conmutaciones, estado_dbg
    );
endinterface

// File: rtl/controlador_baterias.sv
// Two-battery load selector: filtered low-charge detection with hysteresis and
// break-before-make switching through a programmable dead time.
module controlador_baterias #(
    parameter int UMBRAL_BAJO   = 2,
    parameter int HISTERESIS    = 2,
    parameter int CICLOS_FILTRO = 4,
    parameter int TIEMPO_MUERTO = 3
) (
    input logic                   clk,
    input logic                   rst,
    controlador_baterias_if.slave bus
);

    localparam int FW      = $clog2(CICLOS_FILTRO + 1);
    localparam int MAX_CNT = (CICLOS_FILTRO > TIEMPO_MUERTO) ? CICLOS_FILTRO : TIEMPO_MUERTO;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [3:0]    UMBRAL     = 4'(UMBRAL_BAJO);
    localparam logic [3:0]    RECUPERA   = 4'(UMBRAL_BAJO + HISTERESIS);
    localparam logic [FW-1:0] FILTRO_MAX = FW'(CICLOS_FILTRO);
    localparam logic [FW-1:0] FILTRO_SET = FW'(CICLOS_FILTRO - 1);
    localparam logic [CW-1:0] FIN_REPOSO = CW'(CICLOS_FILTRO);
    localparam logic [CW-1:0] FIN_MUERTO = CW'(TIEMPO_MUERTO - 1);

    typedef enum logic [2:0] {
        REPOSO    = 3'd0,
        ACTIVA_B1 = 3'd1,
        ACTIVA_B2 = 3'd2,
        MUERTO    = 3'd3,
        SIN_CARGA = 3'd4
    } estado_t;

    logic [3:0]    carga    [2];
    logic [FW-1:0] cnt_bajo [2];
    logic [1:0]    bajo;

    logic forzar_q, forzar_prev, pulso;

    estado_t       estado, estado_sig;
    logic          destino, destino_sig;
    logic [CW-1:0] cnt_tiempo, cnt_tiempo_sig;
    logic          bateria_activa_q;
    logic [7:0]    num_q;
    logic          cambia;

    assign carga[0] = bus.carga_bateria1;
    assign carga[1] = bus.carga_bateria2;

    // Low filter: the saturating counter counts consecutive low samples; between
    // the low threshold and the recovery level the flag simply holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) cnt_bajo[i] <= '0;
            bajo <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (carga[i] <= UMBRAL) begin
                    if (cnt_bajo[i] != FILTRO_MAX) cnt_bajo[i] <= cnt_bajo[i] + FW'(1);
                    if (cnt_bajo[i] == FILTRO_SET) bajo[i] <= 1'b1;
                end else begin
                    cnt_bajo[i] <= '0;
                    if (carga[i] >= RECUPERA) bajo[i] <= 1'b0;
                end
            end
        end
    end

    // The request is registered, then the edge pulse itself is registered too,
    // so the FSM reacts on the second clock after forzar_cambio rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            forzar_q    <= 1'b0;
            forzar_prev <= 1'b0;
            pulso       <= 1'b0;
        end else begin
            forzar_q    <= bus.forzar_cambio;
            forzar_prev <= forzar_q;
            pulso       <= forzar_q & ~forzar_prev;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado           <= REPOSO;
            destino          <= 1'b0;
            cnt_tiempo       <= '0;
            bateria_activa_q <= 1'b0;
            num_q            <= 8'd0;
        end else begin
            estado     <= estado_sig;
            destino    <= destino_sig;
            cnt_tiempo <= cnt_tiempo_sig;
            if (cambia) begin
                bateria_activa_q <= (estado_sig == ACTIVA_B2);
                if (num_q != 8'hFF) num_q <= num_q + 8'd1;
            end
        end
    end

    always_comb begin
        estado_sig     = estado;
        destino_sig    = destino;
        cnt_tiempo_sig = cnt_tiempo;
        case (estado)
            REPOSO: begin
                if (cnt_tiempo == FIN_REPOSO) begin
                    cnt_tiempo_sig = '0;
                    if (!bajo[0])      estado_sig = ACTIVA_B1;
                    else if (!bajo[1]) estado_sig = ACTIVA_B2;
                    else               estado_sig = SIN_CARGA;
                end else begin
                    cnt_tiempo_sig = cnt_tiempo + CW'(1);
                end
            end
            ACTIVA_B1: begin
                if (bajo[0] && bajo[1]) begin
                    estado_sig = SIN_CARGA;
                end else if ((bajo[0] || pulso) && !bajo[1]) begin
                    estado_sig     = MUERTO;
                    destino_sig    = 1'b1;
                    cnt_tiempo_sig = '0;
                end
            end
            ACTIVA_B2: begin
                if (bajo[0] && bajo[1]) begin
                    estado_sig = SIN_CARGA;
                end else if ((bajo[1] || pulso) && !bajo[0]) begin
                    estado_sig     = MUERTO;
                    destino_sig    = 1'b0;
                    cnt_tiempo_sig = '0;
                end
            end
            MUERTO: begin
                if (cnt_tiempo == FIN_MUERTO) begin
                    cnt_tiempo_sig = '0;
                    // Fall back to the other battery if the target went low meanwhile.
                    if (destino == 1'b0) begin
                        if (!bajo[0])      estado_sig = ACTIVA_B1;
                        else if (!bajo[1]) estado_sig = ACTIVA_B2;
                        else               estado_sig = SIN_CARGA;
                    end else begin
                        if (!bajo[1])      estado_sig = ACTIVA_B2;
                        else if (!bajo[0]) estado_sig = ACTIVA_B1;
                        else               estado_sig = SIN_CARGA;
                    end
                end else begin
                    cnt_tiempo_sig = cnt_tiempo + CW'(1);
                end
            end
            SIN_CARGA: begin
                if (!bajo[0])      estado_sig = ACTIVA_B1;
                else if (!bajo[1]) estado_sig = ACTIVA_B2;
            end
            default: estado_sig = REPOSO;
        endcase
    end

    assign cambia = ((estado_sig == ACTIVA_B1) &&  bateria_activa_q) ||
                    ((estado_sig == ACTIVA_B2) && !bateria_activa_q);

    // Moore outputs decoded straight from the state register.
    assign bus.habilitar_bateria1 = (estado == ACTIVA_B1);
    assign bus.habilitar_bateria2 = (estado == ACTIVA_B2);
    assign bus.conmutando         = (estado == MUERTO);
    assign bus.alarma_sin_carga   = (estado == SIN_CARGA);
    assign bus.bateria_activa     = bateria_activa_q;
    assign bus.num_conmutaciones  = num_q;
    assign bus.estado_dbg         = estado;

endmodule

// File: tb/tb_controlador_baterias.sv
// Scenario bench for controlador_baterias: per-cycle expected output vectors
// {hab1, hab2, activa, conmutando, alarma, num[7:0]} are queued and compared.
module tb_controlador_baterias;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [12:0] exp_q[$];
    logic [12:0] got;
    logic [12:0] exp_v;

    controlador_baterias_if bus();

    controlador_baterias #(
        .UMBRAL_BAJO  (2),
        .HISTERESIS   (2),
        .CICLOS_FILTRO(4),
        .TIEMPO_MUERTO(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] mk(input logic h1, input logic h2, input logic act,
                                       input logic cm, input logic al, input logic [7:0] n);
        return {h1, h2, act, cm, al, n};
    endfunction

    function automatic logic [12:0] salida();
        return {bus.habilitar_bateria1, bus.habilitar_bateria2, bus.bateria_activa,
                bus.conmutando, bus.alarma_sin_carga, bus.num_conmutaciones};
    endfunction

    task automatic test_reset();
        int n;
        rst = 1'b1;
        bus.carga_bateria1 = 4'd10;
        bus.carga_bateria2 = 4'd10;
        bus.forzar_cambio  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = salida();
        checks++;
        if (got !== mk(0, 0, 0, 0, 0, 8'd0)) begin
            failures++;
            $display("FAIL reset_values got=%h expected=%h", got, mk(0, 0, 0, 0, 0, 8'd0));
        end
        rst = 1'b0;
        repeat (4) exp_q.push_back(mk(0, 0, 0, 0, 0, 8'd0));
        repeat (3) exp_q.push_back(mk(1, 0, 0, 0, 0, 8'd0));
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            got = salida();
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL first_enable clock=%0d got=%h expected=%h", c, got, exp_v);
            end
        end
    endtask

    task automatic test_glitch();
        int n;
        repeat (9) exp_q.push_back(mk(1, 0, 0, 0, 0, 8'd0));
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            if (c == 1) bus.carga_bateria1 = 4'd1;
            if (c == 4) bus.carga_bateria1 = 4'd10;
            @(posedge clk); #1;
            got = salida();
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL short_low_glitch clock=%0d got=%h expected=%h", c, got, exp_v);
            end
        end
    endtask

    task automatic test_manual();
        int n;
        repeat (2) exp_q.push_back(mk(1, 0, 0, 0, 0, 8'd0));
        repeat (3) exp_q.push_back(mk(0, 0, 0, 1, 0, 8'd0));
        repeat (4) exp_q.push_back(mk(0, 1, 1, 0, 0, 8'd1));
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            if (c == 1) begin bus.carga_bateria2 = 4'd9; bus.forzar_cambio = 1'b1; end
            if (c == 2) bus.forzar_cambio = 1'b0;
            if (c == 3) bus.forzar_cambio = 1'b1;
            if (c == 4) bus.forzar_cambio = 1'b0;
            @(posedge clk); #1;
            got = salida();
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL manual_switch clock=%0d got=%h expected=%h", c, got, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        repeat (2) exp_q.push_back(mk(0, 1, 1, 0, 0, 8'd1));
        repeat (3) exp_q.push_back(mk(0, 0, 1, 1, 0, 8'd1));
        repeat (3) exp_q.push_back(mk(1, 0, 0, 0, 0, 8'd2));
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            if (c == 1) bus.forzar_cambio = 1'b1;
            if (c == 2) bus.forzar_cambio = 1'b0;
            @(posedge clk); #1;
            got = salida();
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL switch_back clock=%0d got=%h expected=%h", c, got, exp_v);
            end
        end
    endtask

    task automatic test_auto_switch();
        int n;
        repeat (4) exp_q.push_back(mk(1, 0, 0, 0, 0, 8'd2));
        repeat (3) exp_q.push_back(mk(0, 0, 0, 1, 0, 8'd2));
        repeat (3) exp_q.push_back(mk(0, 1, 1, 0, 0, 8'd3));
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            if (c == 1) begin bus.carga_bateria1 = 4'd0; bus.carga_bateria2 = 4'd6; end
            @(posedge clk); #1;
            got = salida();
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL auto_switch clock=%0d got=%h expected=%h", c, got, exp_v);
            end
        end
    endtask

    task automatic test_sin_carga();
        int n;
        repeat (4) exp_q.push_back(mk(0, 1, 1, 0, 0, 8'd3));
        repeat (7) exp_q.push_back(mk(0, 0, 1, 0, 1, 8'd3));
        repeat (2) exp_q.push_back(mk(0, 1, 1, 0, 0, 8'd3));
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            if (c == 1)  bus.carga_bateria2 = 4'd0;
            if (c == 7)  bus.carga_bateria2 = 4'd3;
            if (c == 11) bus.carga_bateria2 = 4'd4;
            @(posedge clk); #1;
            got = salida();
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL no_charge_alarm clock=%0d got=%h expected=%h", c, got, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        repeat (2) exp_q.push_back(mk(0, 1, 1, 0, 0, 8'd3));
        repeat (2) exp_q.push_back(mk(0, 0, 1, 1, 0, 8'd3));
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            if (c == 1) begin bus.carga_bateria1 = 4'd10; bus.forzar_cambio = 1'b1; end
            if (c == 2) bus.forzar_cambio = 1'b0;
            @(posedge clk); #1;
            got = salida();
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL enter_dead_time clock=%0d got=%h expected=%h", c, got, exp_v);
            end
        end
        rst = 1'b1;
        #1;
        got = salida();
        checks++;
        if (got !== mk(0, 0, 0, 0, 0, 8'd0)) begin
            failures++;
            $display("FAIL reset_in_dead_time got=%h expected=%h", got, mk(0, 0, 0, 0, 0, 8'd0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) exp_q.push_back(mk(0, 0, 0, 0, 0, 8'd0));
        repeat (2) exp_q.push_back(mk(1, 0, 0, 0, 0, 8'd0));
        n = exp_q.size();
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            got = salida();
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL restart_after_reset clock=%0d got=%h expected=%h", c, got, exp_v);
            end
        end
    endtask

    task automatic test_saturation();
        for (int t = 1; t <= 256; t++) begin
            if (t == 255) exp_q.push_back(mk(0, 1, 1, 0, 0, 8'd255));
            if (t == 256) exp_q.push_back(mk(1, 0, 0, 0, 0, 8'd255));
            bus.forzar_cambio = 1'b1;
            @(posedge clk); #1;
            bus.forzar_cambio = 1'b0;
            repeat (7) @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                got = salida();
                exp_v = exp_q.pop_front();
                checks++;
                if (got !== exp_v) begin
                    failures++;
                    $display("FAIL count_saturation toggle=%0d got=%h expected=%h", t, got, exp_v);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_glitch();
        test_manual();
        test_back_to_back();
        test_auto_switch();
        test_sin_carga();
        test_reset_mid();
        test_saturation();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout reached=500000ns required=finish_earlier");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule

// File: doc/controlador_baterias.md
# controlador_baterias

Selects which of two batteries powers the load from their 4-bit charge levels. It filters each charge reading against a low threshold with hysteresis and switches between batteries break-before-make, with a programmable dead time. It raises an alarm when neither battery is usable. It sits downstream of the battery charge inputs and drives the load switch enables.

## Interface
- UMBRAL_BAJO, 2: charge ≤ this value is a low sample.
- HISTERESIS, 2: a low flag clears when charge ≥ UMBRAL_BAJO+HISTERESIS. The sum must be ≤ 15.
- CICLOS_FILTRO, 4: consecutive low samples needed to set a low flag. Must be ≥ 1.
- TIEMPO_MUERTO, 3: cycles with both enables off during a switch. Must be ≥ 1.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- carga_bateria1  in  4  charge of battery 1, unsigned.
- carga_bateria2  in  4  charge of battery 2, unsigned.
- forzar_cambio  in  1  manual switch request; acted on at its rising edge.
- habilitar_bateria1  out  1  load switch enable for battery 1.
- habilitar_bateria2  out  1  load switch enable for battery 2.
- bateria_activa  out  1  last battery connected: 0 = B1, 1 = B2.
- conmutando  out  1  high during the dead time.
- alarma_sin_carga  out  1  high when neither battery is usable.
- num_conmutaciones  out  8  count of completed switches; saturates at 255.

## Operation
- **Low filter, one per battery.**
  - The counter increments on each clock with charge ≤ UMBRAL_BAJO and clears on any clock with charge > UMBRAL_BAJO.
  - bajo_i sets on the clock that takes the counter's CICLOS_FILTRO-th consecutive low sample.
  - bajo_i clears on the clock that samples charge ≥ UMBRAL_BAJO+HISTERESIS.
  - Between the two thresholds, bajo_i holds.
- **Manual request.** forzar_cambio is registered. A rising edge produces a one-cycle internal pulse. The pulse is ignored outside ACTIVA_B1 and ACTIVA_B2.
- **FSM states:** REPOSO, ACTIVA_B1, ACTIVA_B2, MUERTO, SIN_CARGA. A destination register `destino` holds the battery being switched to.
- **REPOSO**
  - Stays for CICLOS_FILTRO cycles after reset.
  - Then goes to ACTIVA_B1 if !bajo1, else ACTIVA_B2 if !bajo2, else SIN_CARGA.
- **ACTIVA_B1**
  - bajo1 && bajo2 → SIN_CARGA.
  - (bajo1 or forzar pulse) && !bajo2 → MUERTO with destino = B2.
  - Otherwise stay.
  - A forzar pulse while bajo2 is set is ignored.
- **ACTIVA_B2:** symmetric to ACTIVA_B1.
- **MUERTO**
  - Stays exactly TIEMPO_MUERTO cycles.
  - At expiry: destination usable → that ACTIVA state; else other battery usable → other ACTIVA state; else SIN_CARGA.
- **SIN_CARGA:** !bajo1 → ACTIVA_B1; else !bajo2 → ACTIVA_B2. This exit is direct, with no dead time, because both enables are already off.
- **Switch counting.** Entering an ACTIVA state whose battery differs from bateria_activa updates bateria_activa and increments num_conmutaciones. The count saturates at 255.
- **Mutual exclusion.** habilitar_bateria1 and habilitar_bateria2 are never high in the same cycle.

## Timing
- All outputs are registered Moore outputs:
  - habilitar_bateria1 = (state == ACTIVA_B1).
  - habilitar_bateria2 = (state == ACTIVA_B2).
  - conmutando = (state == MUERTO).
  - alarma_sin_carga = (state == SIN_CARGA).
- **Reset values.** On rst, asynchronously:
  - state = REPOSO, so every enable and flag output is 0.
  - bateria_activa = 0 and num_conmutaciones = 0.
  - Filter counters and bajo flags = 0.
  - Edge detector = 0.
- **First enable.** habilitar_bateria1 goes high after the (CICLOS_FILTRO+1)-th clock following rst release.
- **Auto switch latency.** The charge falls before clock k (k = first low sample).
  - bajo sets at clock k+CICLOS_FILTRO-1.
  - The active enable drops at clock k+CICLOS_FILTRO.
  - The new enable rises at clock k+CICLOS_FILTRO+TIEMPO_MUERTO.
- **Manual latency.** forzar_cambio rises before clock k. The enable drops at clock k+2, and the new enable rises TIEMPO_MUERTO clocks later.
- **Recovery from SIN_CARGA.** The charge reaches the recovery level before clock k. bajo clears at clock k, and the enable rises at clock k+1.
- **Simultaneous events.** If both flags set on the same clock while active, the next state is SIN_CARGA. B1 wins all ties.
- **Reset mid-operation.** Asserting rst in any state, including MUERTO, gives the reset values immediately, with no partial switch completed.

## Test plan
All scenarios use the defaults: UMBRAL_BAJO 2, HISTERESIS 2, CICLOS_FILTRO 4, TIEMPO_MUERTO 3.
1. Reset, then both charges = 10.
   - Required: enables 00 for 4 clocks, then habilitar_bateria1 = 1 at clock 5.
   - Required: bateria_activa = 0, alarma = 0, num_conmutaciones = 0.
2. B1 active; carga_bateria1 set to 0 with carga_bateria2 = 6.
   - Required: habilitar_bateria1 = 0 at the 5th clock and conmutando = 1 for 3 cycles.
   - Required: habilitar_bateria2 = 1 at the 8th clock, bateria_activa = 1, count = 1.
3. B1 active; carga_bateria1 = 1 for 3 clocks, then 10.
   - Required: no switch, enables unchanged, count unchanged.
4. Both charges drop to 0.
   - Required: alarma_sin_carga = 1 and enables 00.
   - Then carga_bateria2 = 3: required to stay in alarm (hysteresis).
   - Then carga_bateria2 = 4: required habilitar_bateria2 = 1 two clocks later and alarma = 0.
5. B1 active, carga_bateria2 = 9; one-cycle forzar_cambio pulse.
   - Required: switch to B2 with 3 dead cycles.
   - A second pulse during MUERTO is required to be ignored; final count +1.
6. rst asserted during MUERTO.
   - Required: all outputs 0 and count 0 immediately.
   - After release, the sequence restarts per scenario 1.
